rle_encoder: RTL and testbench
==============================

Name: rle_encoder

Overview:
- Entropy-prep stage directly downstream of the zigzag reorder stage in the JPEG encoder pipeline.
- Consumes 64 quantised coefficients per block in zigzag order and emits JPEG run/size/amplitude symbols for the Huffman stage.
- Emits DC differences against per-component predictors, and AC run-lengths with ZRL (15,0) and EOB (0,0) insertion.

Parameters:
- COEF_W, 11: coefficient width, signed two's complement.
- NCOMP, 3: number of DC predictors (components).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ena_in  in  1  input coefficient transferred this cycle
- rdy_out  out  1  block can accept a coefficient
- in  in  COEF_W  coefficient, zigzag order
- comp  in  2  component index; sampled with coefficient 0 only
- dc_clr  in  1  clear all DC predictors (restart marker)
- ena_out  out  1  symbol transferred this cycle
- rdy_in  in  1  downstream can accept
- out_run  out  4  zero run (0 for DC)
- out_size  out  4  size category
- out_amp  out  COEF_W  amplitude bits, LSB-aligned, upper bits zero
- out_dc  out  1  symbol is the DC symbol

Behaviour:
- Reset: all outputs, predictors, idx, run, zrl_pend and out_valid cleared; state ACCEPT.
- Handshake:
  - ena_out = out_valid && rdy_in.
  - Output fields are registered and stay stable while out_valid && !rdy_in.
  - rdy_out = (state==ACCEPT) && (!out_valid || rdy_in).
  - Upstream asserts ena_in only when rdy_out is high.
- Latency: a symbol produced by an accepted coefficient is presented on the outputs the following cycle.
- idx (6 bits) counts accepted coefficients and wraps 63→0.
- idx==0 (DC):
  - diff = in − pred[comp], computed in COEF_W+1 bits.
  - Emit run=0, size=cat(diff), amp=enc(diff), out_dc=1.
  - Then pred[comp] <= in.
  - comp ≥ NCOMP uses predictor 0.
- cat(v): 0 if v==0, else bit-length of |v|.
- enc(v): v if v>0; otherwise low cat(v) bits of v−1 (one's complement).
- Inputs are guaranteed within ±(2^(COEF_W−1)−1), so DC size ≤ COEF_W.
- AC, coefficient zero:
  - If run==15: run <= 0, zrl_pend++ (max 3).
  - Otherwise run++.
  - Nothing is emitted.
- AC, coefficient nonzero:
  - If zrl_pend==0: emit (run, cat, enc), then run <= 0.
  - Otherwise latch the symbol into the hold register and enter FLUSH.
- FLUSH state:
  - Each time the output slot frees, emit ZRL (15,0,0) and decrement zrl_pend.
  - When zrl_pend reaches 0, emit the held symbol and return to ACCEPT.
  - rdy_out is low throughout FLUSH.
- idx==63:
  - Zero coefficient: emit EOB (0,0,0) and discard pending ZRLs.
  - Nonzero coefficient: normal emission, no EOB.
  - In both cases run and zrl_pend are cleared for the next block.
- dc_clr:
  - Clears all predictors at the clock edge.
  - If it coincides with an accepted idx==0 coefficient, the diff uses the cleared predictor (value 0).
  - It does not affect run state.
- rst mid-block: the partial block is discarded and the next accepted coefficient is a DC coefficient.

Optional Feature:
- Macro RLE_LAST_FLAG_EN.
- When defined: adds port out_last (out, 1), high on the final symbol of each block (EOB, or the idx-63 symbol); reset value 0.
- When undefined: the port is absent and behaviour is otherwise identical.

Test Plan:
- Fresh predictors, comp=0, block DC=5 with all ACs 0 → (0,3,amp=101,dc=1), then EOB (0,0,0); with the macro, out_last=1 on EOB.
- Next block comp=0, DC=2 → diff −3 → (0,2,amp=00,dc=1); predictor 0 becomes 2. A comp=1 block with DC=4 then gives diff 4 → (0,3,100).
- AC idx1..19 zero, idx20 = −1, remaining zero:
  - Expected symbols: DC, ZRL (15,0), (3,1,amp=0), EOB.
  - rdy_out low for exactly the FLUSH cycle(s).
- idx1..62 zero, idx63 = +1 → DC, ZRL×3, (14,1,amp=1), no EOB. Separately, idx1..63 all zero → DC, EOB only, no ZRLs.
- Backpressure:
  - rdy_in held low 5 cycles with out_valid set.
  - Outputs must stay stable and rdy_out low.
  - No symbol may be lost or duplicated on release.
- rst and dc_clr:
  - Assert rst after idx 30 → next block's first symbol has out_dc=1 and is relative to predictor 0.
  - dc_clr pulse between blocks → next DC diff equals the raw DC value.

Source files
------------

// File: rtl/rle_encoder.sv
// rle_encoder
//   Entropy-prep stage for the JPEG encoder. Takes 64 quantised coefficients
//   per block in zigzag order and produces run/size/amplitude symbols: one
//   DC difference symbol against a per-component predictor, AC run-length
//   symbols with ZRL (15,0) insertion, and EOB (0,0) when the block ends in
//   zeros.
//
//   Optional feature: define RLE_LAST_FLAG_EN to add out_last, which marks the
//   final symbol of each block (EOB, or the symbol of coefficient 63).
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   ena_in, rdy_out   input handshake (ena_in only while rdy_out is high)
//   in                coefficient, signed, zigzag order
//   comp              component index, sampled with coefficient 0 only
//   dc_clr            clear all DC predictors (restart marker)
//   ena_out, rdy_in   output handshake (ena_out = out_valid && rdy_in)
//   out_run           zero run (0 for DC)
//   out_size          size category
//   out_amp           amplitude bits, LSB-aligned, upper bits zero
//   out_dc            symbol is the DC symbol
//   out_last          (RLE_LAST_FLAG_EN only) last symbol of the block
module rle_encoder #(
  parameter int COEF_W = 11,
  parameter int NCOMP  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena_in,
  output logic              rdy_out,
  input  logic [COEF_W-1:0] in,
  input  logic [1:0]        comp,
  input  logic              dc_clr,
  output logic              ena_out,
  input  logic              rdy_in,
  output logic [3:0]        out_run,
  output logic [3:0]        out_size,
  output logic [COEF_W-1:0] out_amp,
  output logic              out_dc
`ifdef RLE_LAST_FLAG_EN
  ,
  output logic              out_last
`endif
);

  localparam logic [0:0] ST_ACCEPT = 1'b0;
  localparam logic [0:0] ST_FLUSH  = 1'b1;

  // Size category: bit length of |v|, 0 for v == 0.
  function automatic logic [3:0] size_cat(input logic signed [COEF_W:0] v);
    logic [COEF_W:0] mag;
    logic [3:0]      c;
    mag = v[COEF_W] ? -v : v;
    c   = '0;
    for (int unsigned i = 0; i < COEF_W + 1; i++) begin
      if (mag[i]) c = 4'(i + 1);
    end
    return c;
  endfunction

  // Amplitude bits: v when positive, else the low c bits of v-1.
  function automatic logic [COEF_W-1:0] amp_bits(input logic signed [COEF_W:0] v,
                                                 input logic [3:0]             c);
    logic [COEF_W:0] t;
    logic [COEF_W:0] mask;
    t    = (!v[COEF_W] && (v != '0)) ? v : v + {(COEF_W+1){1'b1}};
    mask = ~({(COEF_W+1){1'b1}} << c);
    t    = t & mask;
    return t[COEF_W-1:0];
  endfunction

  logic [0:0]        state_q, state_d;
  logic [5:0]        idx_q, idx_d;
  logic [3:0]        run_q, run_d;
  logic [1:0]        zrl_pend_q, zrl_pend_d;
  logic              out_valid_q, out_valid_d;
  logic [3:0]        out_run_q, out_run_d;
  logic [3:0]        out_size_q, out_size_d;
  logic [COEF_W-1:0] out_amp_q, out_amp_d;
  logic              out_dc_q, out_dc_d;
  logic [3:0]        hold_run_q, hold_run_d;
  logic [3:0]        hold_size_q, hold_size_d;
  logic [COEF_W-1:0] hold_amp_q, hold_amp_d;
  logic [COEF_W-1:0] pred_q [NCOMP];
  logic [COEF_W-1:0] pred_d [NCOMP];
`ifdef RLE_LAST_FLAG_EN
  logic              out_last_q, out_last_d;
  logic              hold_last_q, hold_last_d;
  logic              e_last;
`endif

  logic                     slot_free;
  logic                     accept;
  logic [1:0]               comp_sel;
  logic [COEF_W-1:0]        pred_sel;
  logic signed [COEF_W:0]   dc_diff;
  logic signed [COEF_W:0]   ac_val;
  logic [3:0]               dc_size, ac_size;
  logic [COEF_W-1:0]        dc_amp, ac_amp;
  logic                     emit;
  logic [3:0]               e_run, e_size;
  logic [COEF_W-1:0]        e_amp;
  logic                     e_dc;

  assign slot_free = !out_valid_q || rdy_in;
  assign rdy_out   = (state_q == ST_ACCEPT) && slot_free;
  assign accept    = ena_in && rdy_out;
  assign ena_out   = out_valid_q && rdy_in;
  assign out_run   = out_run_q;
  assign out_size  = out_size_q;
  assign out_amp   = out_amp_q;
  assign out_dc    = out_dc_q;
`ifdef RLE_LAST_FLAG_EN
  assign out_last  = out_last_q;
`endif

  // Out-of-range component indices share predictor 0.
  assign comp_sel = (int'(comp) < NCOMP) ? comp : 2'd0;
  // A restart marker on the DC cycle makes the difference use a zero predictor.
  assign pred_sel = dc_clr ? '0 : pred_q[comp_sel];
  assign dc_diff  = $signed({in[COEF_W-1], in}) - $signed({pred_sel[COEF_W-1], pred_sel});
  assign ac_val   = $signed({in[COEF_W-1], in});
  assign dc_size  = size_cat(dc_diff);
  assign dc_amp   = amp_bits(dc_diff, dc_size);
  assign ac_size  = size_cat(ac_val);
  assign ac_amp   = amp_bits(ac_val, ac_size);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    run_d       = run_q;
    zrl_pend_d  = zrl_pend_q;
    out_valid_d = out_valid_q && !rdy_in;
    out_run_d   = out_run_q;
    out_size_d  = out_size_q;
    out_amp_d   = out_amp_q;
    out_dc_d    = out_dc_q;
    hold_run_d  = hold_run_q;
    hold_size_d = hold_size_q;
    hold_amp_d  = hold_amp_q;
    pred_d      = pred_q;
    emit        = 1'b0;
    e_run       = '0;
    e_size      = '0;
    e_amp       = '0;
    e_dc        = 1'b0;
`ifdef RLE_LAST_FLAG_EN
    out_last_d  = out_last_q;
    hold_last_d = hold_last_q;
    e_last      = 1'b0;
`endif

    if (dc_clr) begin
      for (int unsigned i = 0; i < NCOMP; i++) pred_d[i] = '0;
    end

    case (state_q)
      ST_ACCEPT: begin
        if (accept) begin
          idx_d = idx_q + 6'd1;
          if (idx_q == 6'd0) begin
            emit   = 1'b1;
            e_size = dc_size;
            e_amp  = dc_amp;
            e_dc   = 1'b1;
            pred_d[comp_sel] = in;
          end else if (in == '0) begin
            if (idx_q == 6'd63) begin
              // Block ends in zeros: EOB replaces any pending ZRLs.
              emit       = 1'b1;
              run_d      = '0;
              zrl_pend_d = '0;
`ifdef RLE_LAST_FLAG_EN
              e_last     = 1'b1;
`endif
            end else if (run_q == 4'd15) begin
              run_d = '0;
              if (zrl_pend_q != 2'd3) zrl_pend_d = zrl_pend_q + 2'd1;
            end else begin
              run_d = run_q + 4'd1;
            end
          end else if (zrl_pend_q == 2'd0) begin
            emit   = 1'b1;
            e_run  = run_q;
            e_size = ac_size;
            e_amp  = ac_amp;
            run_d  = '0;
`ifdef RLE_LAST_FLAG_EN
            e_last = (idx_q == 6'd63);
`endif
          end else begin
            // ZRLs must go out first; park the symbol until they drain.
            hold_run_d  = run_q;
            hold_size_d = ac_size;
            hold_amp_d  = ac_amp;
            run_d       = '0;
            state_d     = ST_FLUSH;
`ifdef RLE_LAST_FLAG_EN
            hold_last_d = (idx_q == 6'd63);
`endif
          end
        end
      end
      default: begin
        if (slot_free) begin
          emit = 1'b1;
          if (zrl_pend_q != 2'd0) begin
            e_run      = 4'd15;
            zrl_pend_d = zrl_pend_q - 2'd1;
          end else begin
            e_run   = hold_run_q;
            e_size  = hold_size_q;
            e_amp   = hold_amp_q;
            state_d = ST_ACCEPT;
`ifdef RLE_LAST_FLAG_EN
            e_last  = hold_last_q;
`endif
          end
        end
      end
    endcase

    if (emit) begin
      out_valid_d = 1'b1;
      out_run_d   = e_run;
      out_size_d  = e_size;
      out_amp_d   = e_amp;
      out_dc_d    = e_dc;
`ifdef RLE_LAST_FLAG_EN
      out_last_d  = e_last;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ACCEPT;
      idx_q       <= '0;
      run_q       <= '0;
      zrl_pend_q  <= '0;
      out_valid_q <= 1'b0;
      out_run_q   <= '0;
      out_size_q  <= '0;
      out_amp_q   <= '0;
      out_dc_q    <= 1'b0;
      hold_run_q  <= '0;
      hold_size_q <= '0;
      hold_amp_q  <= '0;
      for (int unsigned i = 0; i < NCOMP; i++) pred_q[i] <= '0;
`ifdef RLE_LAST_FLAG_EN
      out_last_q  <= 1'b0;
      hold_last_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      run_q       <= run_d;
      zrl_pend_q  <= zrl_pend_d;
      out_valid_q <= out_valid_d;
      out_run_q   <= out_run_d;
      out_size_q  <= out_size_d;
      out_amp_q   <= out_amp_d;
      out_dc_q    <= out_dc_d;
      hold_run_q  <= hold_run_d;
      hold_size_q <= hold_size_d;
      hold_amp_q  <= hold_amp_d;
      for (int unsigned i = 0; i < NCOMP; i++) pred_q[i] <= pred_d[i];
`ifdef RLE_LAST_FLAG_EN
      out_last_q  <= out_last_d;
      hold_last_q <= hold_last_d;
`endif
    end
  end

endmodule

// File: tb/tb_rle_encoder.sv
// tb_rle_encoder
//   Directed bench for rle_encoder. A block-level model derives the expected
//   symbol stream from the JPEG run-length rules; a compare process checks
//   every transferred symbol against it in order.
module tb_rle_encoder;

  localparam int COEF_W = 11;
  localparam int NCOMP  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              ena_in;
  logic              rdy_out;
  logic [COEF_W-1:0] in;
  logic [1:0]        comp;
  logic              dc_clr;
  logic              ena_out;
  logic              rdy_in;
  logic [3:0]        out_run;
  logic [3:0]        out_size;
  logic [COEF_W-1:0] out_amp;
  logic              out_dc;
  logic              dut_last;

  rle_encoder #(.COEF_W(COEF_W), .NCOMP(NCOMP)) dut (
    .clk      (clk),
    .rst      (rst),
    .ena_in   (ena_in),
    .rdy_out  (rdy_out),
    .in       (in),
    .comp     (comp),
    .dc_clr   (dc_clr),
    .ena_out  (ena_out),
    .rdy_in   (rdy_in),
    .out_run  (out_run),
    .out_size (out_size),
    .out_amp  (out_amp),
    .out_dc   (out_dc)
`ifdef RLE_LAST_FLAG_EN
    ,
    .out_last (dut_last)
`endif
  );
`ifndef RLE_LAST_FLAG_EN
  assign dut_last = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]        run;
    logic [3:0]        size;
    logic [COEF_W-1:0] amp;
    logic              dc;
    logic              last;
  } sym_t;

  sym_t exp_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;
  int   pred_m [NCOMP];
  int   blk [64];
  int   flush_cnt = 0;
  bit   count_flush = 1'b0;
  bit   bp_en = 1'b0;

  function automatic int m_cat(input int v);
    int m, s;
    m = (v < 0) ? -v : v;
    s = 0;
    while (m > 0) begin
      m = m >> 1;
      s++;
    end
    return s;
  endfunction

  function automatic int m_enc(input int v);
    int s;
    s = m_cat(v);
    if (v > 0) return v;
    return (v - 1) & ((1 << s) - 1);
  endfunction

  function automatic sym_t mk(input int r, input int s, input int a, input int dc, input int last);
    sym_t x;
    x.run  = 4'(r);
    x.size = 4'(s);
    x.amp  = COEF_W'(a);
    x.dc   = 1'(dc);
`ifdef RLE_LAST_FLAG_EN
    x.last = 1'(last);
`else
    x.last = 1'b0;
`endif
    return x;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_sym(input string name, input sym_t got, input sym_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got run=%0d size=%0d amp=%0d dc=%0d last=%0d, expected run=%0d size=%0d amp=%0d dc=%0d last=%0d",
               name, got.run, got.size, got.amp, got.dc, got.last,
               exp.run, exp.size, exp.amp, exp.dc, exp.last);
    end
  endtask

  // Expected symbols for the first n coefficients of blk: zero runs longer
  // than 15 become ZRLs, a trailing zero coefficient 63 becomes EOB.
  task automatic model_block(input int n, input int cmp, input bit clr);
    int p, diff, zeros;
    if (clr) for (int i = 0; i < NCOMP; i++) pred_m[i] = 0;
    p    = (cmp < NCOMP) ? cmp : 0;
    diff = blk[0] - pred_m[p];
    exp_q.push_back(mk(0, m_cat(diff), m_enc(diff), 1, 0));
    pred_m[p] = blk[0];
    zeros = 0;
    for (int k = 1; k < n; k++) begin
      if (blk[k] == 0) begin
        zeros++;
      end else begin
        while (zeros > 15) begin
          exp_q.push_back(mk(15, 0, 0, 0, 0));
          zeros -= 16;
        end
        exp_q.push_back(mk(zeros, m_cat(blk[k]), m_enc(blk[k]), 0, (k == 63) ? 1 : 0));
        zeros = 0;
      end
    end
    if (n == 64 && blk[63] == 0) exp_q.push_back(mk(0, 0, 0, 0, 1));
  endtask

  task automatic set_blk(input int dc);
    for (int i = 0; i < 64; i++) blk[i] = 0;
    blk[0] = dc;
  endtask

  task automatic put(input int c, input int cmp, input bit clr);
    int t;
    t = 0;
    @(negedge clk);
    while (!rdy_out) begin
      if (t >= 500) begin
        n_checks++;
        n_fails++;
        $display("FAIL put_timeout: rdy_out stayed %0d, expected 1", rdy_out);
        return;
      end
      @(negedge clk);
      t++;
    end
    in     = COEF_W'(c);
    comp   = 2'(cmp);
    dc_clr = clr;
    ena_in = 1'b1;
    @(posedge clk);
    #1;
    ena_in = 1'b0;
    dc_clr = 1'b0;
  endtask

  task automatic send(input int from, input int n, input int cmp, input bit clr);
    for (int k = from; k < n; k++) put(blk[k], cmp, clr && (k == 0));
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    chk("drain_pending", exp_q.size(), 0);
  endtask

  // Every transferred symbol must be the next one the model predicts.
  always @(negedge clk) begin
    sym_t got;
    if (!rst && ena_out) begin
      got = {out_run, out_size, out_amp, out_dc, dut_last};
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL unexpected_symbol: got run=%0d size=%0d amp=%0d dc=%0d, expected none",
                 out_run, out_size, out_amp, out_dc);
      end else begin
        chk_sym("symbol", got, exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (count_flush && !rst && rdy_in && !rdy_out) flush_cnt++;
  end

  always @(posedge clk) begin
    if (bp_en) begin
      #1;
      rdy_in = ($urandom_range(0, 2) != 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sym_t snap;
    rst = 1'b1; ena_in = 1'b0; in = '0; comp = '0; dc_clr = 1'b0; rdy_in = 1'b1;
    for (int i = 0; i < NCOMP; i++) pred_m[i] = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_rdy_out", rdy_out, 1);
    chk("reset_ena_out", ena_out, 0);
    chk("reset_fields", {out_run, out_size, out_amp, out_dc, dut_last}, 0);

    // DC 5 with all-zero ACs
    set_blk(5);
    model_block(64, 0, 0);
    chk_sym("pin_t1_dc", exp_q[0], mk(0, 3, 5, 1, 0));
    chk_sym("pin_t1_eob", exp_q[1], mk(0, 0, 0, 0, 1));
    flush_cnt = 0; count_flush = 1'b1;
    send(0, 64, 0, 0);
    drain();
    count_flush = 1'b0;
    chk("flush_t1", flush_cnt, 0);

    // DC 2 on comp 0: diff -3
    set_blk(2);
    model_block(64, 0, 0);
    chk_sym("pin_t2_dc", exp_q[0], mk(0, 2, 0, 1, 0));
    send(0, 64, 0, 0);
    drain();

    // comp 1, DC 4 against a fresh predictor
    set_blk(4);
    model_block(64, 1, 0);
    chk_sym("pin_t3_dc", exp_q[0], mk(0, 3, 4, 1, 0));
    send(0, 64, 1, 0);
    drain();

    // idx 20 = -1 after 19 zeros: DC, ZRL, (3,1,0), EOB
    set_blk(2);
    blk[20] = -1;
    model_block(64, 0, 0);
    chk("pin_t4_count", exp_q.size(), 4);
    chk_sym("pin_t4_zrl", exp_q[1], mk(15, 0, 0, 0, 0));
    chk_sym("pin_t4_sym", exp_q[2], mk(3, 1, 0, 0, 0));
    flush_cnt = 0; count_flush = 1'b1;
    send(0, 64, 0, 0);
    drain();
    count_flush = 1'b0;
    chk("flush_t4", flush_cnt, 2);

    // idx 63 = +1 after 62 zeros: DC, ZRL x3, (14,1,1), no EOB
    set_blk(-5);
    blk[63] = 1;
    model_block(64, 2, 0);
    chk("pin_t5_count", exp_q.size(), 5);
    chk_sym("pin_t5_dc", exp_q[0], mk(0, 3, 2, 1, 0));
    chk_sym("pin_t5_last", exp_q[4], mk(14, 1, 1, 0, 1));
    flush_cnt = 0; count_flush = 1'b1;
    send(0, 64, 2, 0);
    drain();
    count_flush = 1'b0;
    chk("flush_t5", flush_cnt, 4);

    // comp 3 falls back to predictor 0 (holds 2): diff 8, then EOB only
    set_blk(10);
    model_block(64, 3, 0);
    chk("pin_t6_count", exp_q.size(), 2);
    chk_sym("pin_t6_dc", exp_q[0], mk(0, 4, 8, 1, 0));
    flush_cnt = 0; count_flush = 1'b1;
    send(0, 64, 3, 0);
    drain();
    count_flush = 1'b0;
    chk("flush_t6", flush_cnt, 0);

    // Backpressure: hold rdy_in low 5 cycles with the DC symbol pending
    set_blk(7);
    blk[1] = 3; blk[2] = -2; blk[5] = 100;
    model_block(64, 0, 0);
    chk_sym("pin_t7_dc", exp_q[0], mk(0, 2, 0, 1, 0));
    rdy_in = 1'b0;
    put(blk[0], 0, 0);
    @(negedge clk);
    snap = {out_run, out_size, out_amp, out_dc, dut_last};
    chk_sym("bp_fields", snap, mk(0, 2, 0, 1, 0));
    for (int i = 0; i < 5; i++) begin
      chk("bp_rdy_out", rdy_out, 0);
      chk("bp_ena_out", ena_out, 0);
      chk_sym("bp_stable", {out_run, out_size, out_amp, out_dc, dut_last}, snap);
      @(negedge clk);
    end
    @(posedge clk);
    #1 rdy_in = 1'b1;
    send(1, 64, 0, 0);
    drain();

    // Extreme values under random backpressure
    set_blk(-1023);
    blk[1] = 1023; blk[18] = -1023; blk[51] = -7; blk[52] = 15;
    model_block(64, 1, 0);
    chk("pin_t8_count", exp_q.size(), 9);
    chk_sym("pin_t8_dc", exp_q[0], mk(0, 11, 1020, 1, 0));
    chk_sym("pin_t8_ac", exp_q[1], mk(0, 10, 1023, 0, 0));
    chk_sym("pin_t8_neg", exp_q[3], mk(0, 10, 0, 0, 0));
    bp_en = 1'b1;
    send(0, 64, 1, 0);
    drain();
    bp_en = 1'b0;
    @(posedge clk);
    #1 rdy_in = 1'b1;

    // Reset after idx 30: partial block abandoned, predictors cleared
    set_blk(9);
    for (int k = 1; k < 31; k++) blk[k] = 1;
    model_block(31, 0, 0);
    send(0, 31, 0, 0);
    drain();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < NCOMP; i++) pred_m[i] = 0;
    set_blk(6);
    model_block(64, 0, 0);
    chk_sym("pin_t9_dc", exp_q[0], mk(0, 3, 6, 1, 0));
    send(0, 64, 0, 0);
    drain();

    // dc_clr pulse between blocks: diff equals raw DC
    @(negedge clk);
    dc_clr = 1'b1;
    @(posedge clk);
    #1 dc_clr = 1'b0;
    for (int i = 0; i < NCOMP; i++) pred_m[i] = 0;
    set_blk(6);
    model_block(64, 0, 0);
    chk_sym("pin_t10_dc", exp_q[0], mk(0, 3, 6, 1, 0));
    send(0, 64, 0, 0);
    drain();

    // dc_clr together with the DC coefficient
    set_blk(-6);
    model_block(64, 0, 1);
    chk_sym("pin_t11_dc", exp_q[0], mk(0, 3, 1, 1, 0));
    send(0, 64, 0, 1);
    drain();

    // comp 1 predictor was cleared by the previous dc_clr as well
    set_blk(5);
    model_block(64, 1, 0);
    chk_sym("pin_t12_dc", exp_q[0], mk(0, 3, 5, 1, 0));
    send(0, 64, 1, 0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
